// File: rtl/rev_count_monitor_pkg.sv
// Shared definitions for the reversible-counter receive monitor.
// Direction constants are the same encoding the counter itself uses.
package rev_count_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/rev_count_monitor_step_check.sv
// Combinational contract check: is this cnt the legal successor of prev_cnt,
// and does Rc agree with the same-cycle s and cnt.
module rev_step_check
  import rev_count_monitor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] prev_cnt_i,
  input  logic             prev_s_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             s_i,
  input  logic             rc_i,
  output logic             step_ok_o,
  output logic             rc_ok_o
);

  logic [WIDTH-1:0] exp_cnt_s;
  logic             rc_exp_s;

  // Expected successor uses the previous direction; Rc uses the current one.
  always_comb begin
    if (prev_s_i == DIR_UP) begin
      exp_cnt_s = prev_cnt_i + WIDTH'(1);
    end else begin
      exp_cnt_s = prev_cnt_i - WIDTH'(1);
    end
    if (s_i == DIR_UP) begin
      rc_exp_s = (cnt_i == {WIDTH{1'b1}});
    end else begin
      rc_exp_s = (cnt_i == {WIDTH{1'b0}});
    end
    step_ok_o = (cnt_i == exp_cnt_s);
    rc_ok_o   = (rc_i == rc_exp_s);
  end

endmodule

// File: rtl/rev_count_monitor.sv
// Monitor for the 16-bit reversible counter: locks onto a legal count stream,
// extends it with a signed wrap count and records step / ripple-carry errors.
module rev_count_monitor
  import rev_count_monitor_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int WRAP_W = 8,
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              s_i,
  input  logic [WIDTH-1:0]  cnt_i,
  input  logic              rc_i,
  output logic [WRAP_W-1:0] wraps_o,
  output logic              locked_o,
  output logic              step_err_o,
  output logic              rc_err_o,
  output logic [ERR_W-1:0]  err_cnt_o,
  output logic [WIDTH-1:0]  first_err_val_o
);

  localparam int GR_W = $clog2(LOCK_N + 1);

  state_e            state_q, state_d;
  logic [GR_W-1:0]   good_run_q, good_run_d;
  logic [WIDTH-1:0]  prev_cnt_q, prev_cnt_d;
  logic              prev_s_q, prev_s_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              locked_q, locked_d;
  logic              step_err_q, step_err_d;
  logic              rc_err_q, rc_err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]  first_q, first_d;
  logic              step_ok_s, rc_ok_s;

  rev_step_check #(.WIDTH(WIDTH)) u_check (
    .prev_cnt_i (prev_cnt_q),
    .prev_s_i   (prev_s_q),
    .cnt_i      (cnt_i),
    .s_i        (s_i),
    .rc_i       (rc_i),
    .step_ok_o  (step_ok_s),
    .rc_ok_o    (rc_ok_s)
  );

  // Next-state logic for the FSM, wrap extension and error capture.
  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    prev_cnt_d = cnt_i;
    prev_s_d   = s_i;
    wraps_d    = wraps_q;
    step_err_d = step_err_q;
    rc_err_d   = rc_err_q;
    err_cnt_d  = err_cnt_q;
    first_d    = first_q;
    if (!en_i) begin
      state_d    = ST_IDLE;
      good_run_d = {GR_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_ACQ;
          good_run_d = {GR_W{1'b0}};
        end
        ST_ACQ: begin
          if (step_ok_s && rc_ok_s) begin
            good_run_d = good_run_q + GR_W'(1);
            if (good_run_d == GR_W'(LOCK_N)) begin
              state_d = ST_TRACK;
            end else begin
              state_d = ST_ACQ;
            end
          end else begin
            good_run_d = {GR_W{1'b0}};
          end
        end
        ST_TRACK: begin
          // A coincident step and Rc fault is a single error event.
          if (!step_ok_s || !rc_ok_s) begin
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end else begin
              err_cnt_d = err_cnt_q;
            end
            if (err_cnt_q == {ERR_W{1'b0}}) begin
              first_d = cnt_i;
            end else begin
              first_d = first_q;
            end
          end else begin
            err_cnt_d = err_cnt_q;
          end
          if (!rc_ok_s) begin
            rc_err_d = 1'b1;
          end else begin
            rc_err_d = rc_err_q;
          end
          if (!step_ok_s) begin
            step_err_d = 1'b1;
            state_d    = ST_ACQ;
            good_run_d = {GR_W{1'b0}};
          end else if (prev_cnt_q == {WIDTH{1'b1}} && cnt_i == {WIDTH{1'b0}}) begin
            wraps_d = wraps_q + WRAP_W'(1);
          end else if (prev_cnt_q == {WIDTH{1'b0}} && cnt_i == {WIDTH{1'b1}}) begin
            wraps_d = wraps_q - WRAP_W'(1);
          end else begin
            wraps_d = wraps_q;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          good_run_d = {GR_W{1'b0}};
        end
      endcase
    end
    locked_d = (state_d == ST_TRACK);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      good_run_q <= {GR_W{1'b0}};
      prev_cnt_q <= {WIDTH{1'b0}};
      prev_s_q   <= 1'b0;
      wraps_q    <= {WRAP_W{1'b0}};
      locked_q   <= 1'b0;
      step_err_q <= 1'b0;
      rc_err_q   <= 1'b0;
      err_cnt_q  <= {ERR_W{1'b0}};
      first_q    <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      prev_cnt_q <= prev_cnt_d;
      prev_s_q   <= prev_s_d;
      wraps_q    <= wraps_d;
      locked_q   <= locked_d;
      step_err_q <= step_err_d;
      rc_err_q   <= rc_err_d;
      err_cnt_q  <= err_cnt_d;
      first_q    <= first_d;
    end
  end

  assign wraps_o         = wraps_q;
  assign locked_o        = locked_q;
  assign step_err_o      = step_err_q;
  assign rc_err_o        = rc_err_q;
  assign err_cnt_o       = err_cnt_q;
  assign first_err_val_o = first_q;

endmodule

// File: tb/tb_rev_count_monitor.sv
// Bench for rev_count_monitor: a hand-computed vector table, directed corner
// sequences and a randomized run, all checked against an integer-level model.
module tb_rev_count_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i, s_i, rc_i;
  logic [15:0] cnt_i;
  logic [7:0]  wraps_o, err_cnt_o;
  logic        locked_o, step_err_o, rc_err_o;
  logic [15:0] first_err_val_o;

  int errors = 0;
  int checks = 0;

  // Reference model state (plain integers)
  bit m_engaged, m_tracking, m_step_err, m_rc_err, m_prev_s;
  int m_run, m_errs, m_first, m_wrap_pos, m_prev;

  // Stimulus bookkeeping
  logic [15:0] last_cnt;
  bit          last_s;

  typedef struct {
    bit          en;
    bit          s;
    logic [15:0] cnt;
    bit          rc;
    bit          locked;
    bit          step_err;
    bit          rc_err;
    logic [7:0]  err;
    logic [15:0] first;
    logic [7:0]  wraps;
  } vec_t;

  vec_t tbl[9];

  rev_count_monitor dut (
    .clk             (clk),
    .rst             (rst),
    .en_i            (en_i),
    .s_i             (s_i),
    .cnt_i           (cnt_i),
    .rc_i            (rc_i),
    .wraps_o         (wraps_o),
    .locked_o        (locked_o),
    .step_err_o      (step_err_o),
    .rc_err_o        (rc_err_o),
    .err_cnt_o       (err_cnt_o),
    .first_err_val_o (first_err_val_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rc_for(input bit s, input logic [15:0] c);
    return s ? (c == 16'h0000) : (c == 16'hFFFF);
  endfunction

  task automatic model_reset();
    m_engaged = 0; m_tracking = 0; m_step_err = 0; m_rc_err = 0; m_prev_s = 0;
    m_run = 0; m_errs = 0; m_first = 0; m_wrap_pos = 0; m_prev = 0;
  endtask

  task automatic model_step(input bit en, input bit s, input int c, input bit rc);
    int  want;
    bit  step_good, rc_good;
    want      = (m_prev + (m_prev_s ? 65535 : 1)) % 65536;
    step_good = (c == want);
    rc_good   = (rc == (s ? (c == 0) : (c == 65535)));
    if (!en) begin
      m_engaged = 0; m_tracking = 0; m_run = 0;
    end else if (!m_engaged) begin
      m_engaged = 1; m_run = 0;
    end else if (!m_tracking) begin
      m_run = (step_good && rc_good) ? m_run + 1 : 0;
      if (m_run >= 4) m_tracking = 1;
    end else begin
      if (!step_good || !rc_good) begin
        if (m_errs == 0) m_first = c;
        if (m_errs < 255) m_errs++;
      end
      if (!rc_good) m_rc_err = 1;
      if (!step_good) begin
        m_step_err = 1; m_tracking = 0; m_run = 0;
      end else if (m_prev == 65535 && c == 0) begin
        m_wrap_pos++;
      end else if (m_prev == 0 && c == 65535) begin
        m_wrap_pos--;
      end
    end
    m_prev   = c;
    m_prev_s = s;
  endtask

  task automatic compare_model();
    check("locked", locked_o, m_tracking);
    check("step_err", step_err_o, m_step_err);
    check("rc_err", rc_err_o, m_rc_err);
    check("err_cnt", err_cnt_o, m_errs);
    check("first_err_val", first_err_val_o, m_first);
    check("wraps", wraps_o, m_wrap_pos & 255);
  endtask

  task automatic apply(input bit en, input bit s, input logic [15:0] c, input bit rc);
    @(negedge clk);
    en_i = en; s_i = s; cnt_i = c; rc_i = rc;
    @(posedge clk);
    model_step(en, s, int'(c), rc);
    #1;
    compare_model();
    last_cnt = c;
    last_s   = s;
  endtask

  task automatic legal(input bit s);
    logic [15:0] c;
    c = last_s ? last_cnt - 16'd1 : last_cnt + 16'd1;
    apply(1'b1, s, c, rc_for(s, c));
  endtask

  task automatic bad_rc(input bit s);
    logic [15:0] c;
    c = last_s ? last_cnt - 16'd1 : last_cnt + 16'd1;
    apply(1'b1, s, c, !rc_for(s, c));
  endtask

  // One disabled cycle, then re-enable at value v so the monitor re-references.
  task automatic reengage(input logic [15:0] v, input bit s);
    apply(1'b0, s, v, 1'b0);
    apply(1'b1, s, v, rc_for(s, v));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en_i = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd0};
    tbl[1] = '{1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd0};
    tbl[2] = '{1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd0};
    tbl[3] = '{1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd0};
    tbl[4] = '{1'b1, 1'b0, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd0};
    tbl[5] = '{1'b1, 1'b0, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd0};
    tbl[6] = '{1'b1, 1'b0, 16'h0006, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 16'h0006, 8'd0};
    tbl[7] = '{1'b1, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 16'h0006, 8'd0};
    tbl[8] = '{1'b1, 1'b0, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 16'h0006, 8'd0};

    rst = 1'b1; en_i = 1'b0; s_i = 1'b0; cnt_i = 16'h0000; rc_i = 1'b0;
    last_cnt = 16'h0000; last_s = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("reset_locked", locked_o, 0);
    check("reset_step_err", step_err_o, 0);
    check("reset_rc_err", rc_err_o, 0);
    check("reset_err_cnt", err_cnt_o, 0);
    check("reset_first", first_err_val_o, 0);
    check("reset_wraps", wraps_o, 0);
    @(negedge clk); rst = 1'b0;

    // Table: lock from 0x0000, then an Rc fault and a step fault
    foreach (tbl[i]) begin
      apply(tbl[i].en, tbl[i].s, tbl[i].cnt, tbl[i].rc);
      check($sformatf("tbl%0d_locked", i), locked_o, tbl[i].locked);
      check($sformatf("tbl%0d_step_err", i), step_err_o, tbl[i].step_err);
      check($sformatf("tbl%0d_rc_err", i), rc_err_o, tbl[i].rc_err);
      check($sformatf("tbl%0d_err_cnt", i), err_cnt_o, tbl[i].err);
      check($sformatf("tbl%0d_first", i), first_err_val_o, tbl[i].first);
      check($sformatf("tbl%0d_wraps", i), wraps_o, tbl[i].wraps);
    end

    // Up through 0xFFFF->0x0000, then down through 0x0000->0xFFFF
    do_reset();
    reengage(16'hFFF8, 1'b0);
    repeat (8) legal(1'b0);
    check("wrap_up_cnt", cnt_i, 16'h0000);
    check("wrap_up", wraps_o, 1);
    legal(1'b1);
    legal(1'b1);
    legal(1'b1);
    check("wrap_dn_cnt", cnt_i, 16'hFFFF);
    check("wrap_dn", wraps_o, 0);
    check("wrap_no_err", err_cnt_o, 0);

    // Direction change: s sampled with 0x0064 governs the step to 0x0063
    do_reset();
    reengage(16'h0060, 1'b0);
    repeat (3) legal(1'b0);
    legal(1'b1);
    legal(1'b1);
    check("dir_cnt", cnt_i, 16'h0063);
    check("dir_locked", locked_o, 1);
    check("dir_no_err", err_cnt_o, 0);
    check("dir_no_step_err", step_err_o, 0);

    // Jump 0x0100 -> 0x0105 in TRACK, then relock
    reengage(16'h00F0, 1'b0);
    repeat (16) legal(1'b0);
    check("jump_pre_locked", locked_o, 1);
    apply(1'b1, 1'b0, 16'h0105, 1'b0);
    check("jump_step_err", step_err_o, 1);
    check("jump_err_cnt", err_cnt_o, 1);
    check("jump_first", first_err_val_o, 16'h0105);
    check("jump_unlocked", locked_o, 0);
    repeat (3) legal(1'b0);
    check("relock_not_yet", locked_o, 0);
    legal(1'b0);
    check("relock", locked_o, 1);

    // Rc fault at 0x1234 keeps lock; then saturate the error counter
    reengage(16'h122F, 1'b0);
    repeat (4) legal(1'b0);
    apply(1'b1, 1'b0, 16'h1234, 1'b1);
    check("rcf_rc_err", rc_err_o, 1);
    check("rcf_err_cnt", err_cnt_o, 2);
    check("rcf_locked", locked_o, 1);
    check("rcf_first", first_err_val_o, 16'h0105);
    repeat (256) bad_rc(1'b0);
    check("sat_err_cnt", err_cnt_o, 8'hFF);
    check("sat_locked", locked_o, 1);

    // wraps=3, err_cnt=2; en=0 holds; then async reset mid-TRACK
    do_reset();
    for (int k = 0; k < 3; k++) begin
      reengage(16'hFFF8, 1'b0);
      repeat (8) legal(1'b0);
    end
    bad_rc(1'b0);
    bad_rc(1'b0);
    check("pre_rst_wraps", wraps_o, 3);
    check("pre_rst_err", err_cnt_o, 2);
    apply(1'b0, 1'b0, 16'h0000, 1'b0);
    check("hold_locked", locked_o, 0);
    check("hold_wraps", wraps_o, 3);
    check("hold_err", err_cnt_o, 2);
    check("hold_rc_err", rc_err_o, 1);
    apply(1'b1, 1'b0, 16'h0010, 1'b0);
    repeat (4) legal(1'b0);
    check("mid_locked", locked_o, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_locked", locked_o, 0);
    check("arst_wraps", wraps_o, 0);
    check("arst_err", err_cnt_o, 0);
    check("arst_rc_err", rc_err_o, 0);
    check("arst_first", first_err_val_o, 0);
    model_reset();
    @(negedge clk); rst = 1'b0;

    // Randomized stream against the model
    reengage(16'($urandom), 1'b0);
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit ns;
      r  = $urandom_range(0, 99);
      ns = ($urandom_range(0, 19) == 0) ? !last_s : last_s;
      if (n % 500 == 250) begin
        reengage(16'hFFF0 + 16'($urandom_range(0, 8)), ns);
      end else if (r < 3) begin
        apply(1'b0, ns, 16'($urandom), 1'b0);
      end else if (r < 6) begin
        logic [15:0] c;
        c = 16'($urandom);
        apply(1'b1, ns, c, rc_for(ns, c));
      end else if (r < 9) begin
        bad_rc(ns);
      end else begin
        legal(ns);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
